// File: rtl/instr_sequencer_if.sv
// Bundle of signals between the instruction sequencer, its program loader/controller and the
// 9-bit processor core.
//   master : drives Start/prog_len, the store write port and the core's Done pulse;
//            observes DIN/Run/PC and the status flags.
//   slave  : the sequencer itself (mirror directions).
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              Start;
    logic [ADDR_W:0]   prog_len;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [8:0]        load_data;
    logic              Done;
    logic [8:0]        DIN;
    logic              Run;
    logic [ADDR_W-1:0] PC;
    logic              busy;
    logic              halted;
    logic              error;

    modport master (
        output Start, prog_len, load_en, load_addr, load_data, Done,
        input  DIN, Run, PC, busy, halted, error
    );

    modport slave (
        input  Start, prog_len, load_en, load_addr, load_data, Done,
        output DIN, Run, PC, busy, halted, error
    );
endinterface

// File: rtl/instr_sequencer.sv
// Done-paced instruction feeder for the 9-bit processor core.
// Holds a 2**ADDR_W x 9 program store, issues one word at a time on DIN with a one-cycle Run
// strobe, supplies the immediate word of an MVI on the following cycle, then waits for Done.
// A missing Done for TIMEOUT cycles raises error.
// Ports:
//   Clock  : processor clock, rising-edge
//   Resetn : asynchronous active-low reset
//   bus    : slave side of instr_sequencer_if (start/length, store write port, Done in;
//            DIN/Run/PC and busy/halted/error out, all registered)
module instr_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter logic [2:0]  MVI_OP  = 3'b001,
    parameter int unsigned TIMEOUT = 15
) (
    input logic              Clock,
    input logic              Resetn,
    instr_sequencer_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LW    = ADDR_W + 1;
    localparam int unsigned TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StImm, StWait, StHalt, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LW-1:0]     len_q, len_d;
    logic [8:0]        din_q, din_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;

    logic [8:0]        mem_q [DEPTH];
    logic              idle_like;
    logic              last_word;
    logic [ADDR_W-1:0] pc_inc;

    assign idle_like = (state_q == StIdle) || (state_q == StHalt) || (state_q == StErr);
    assign pc_inc    = pc_q + ADDR_W'(1);
    // Length compare is one bit wider so length == DEPTH ends at PC == DEPTH-1 without wrap.
    assign last_word = (({1'b0, pc_q} + LW'(1)) == len_q);

    // Program store: not reset; writes only land while no program is in flight.
    always_ff @(posedge Clock) begin
        if (bus.load_en && idle_like) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        din_d   = din_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle, StHalt, StErr: begin
                if (bus.Start) begin
                    if (bus.prog_len == '0) begin
                        state_d = StHalt;
                    end else if (bus.prog_len > LW'(DEPTH)) begin
                        state_d = StErr;
                    end else begin
                        state_d = StIssue;
                        len_d   = bus.prog_len;
                        pc_d    = '0;
                        din_d   = mem_q[0];
                    end
                end
            end
            StIssue: begin
                if (din_q[8:6] == MVI_OP) begin
                    if (last_word) begin
                        state_d = StErr; // immediate word would lie past the program end
                    end else begin
                        state_d = StImm;
                        pc_d    = pc_inc;
                        din_d   = mem_q[pc_inc];
                    end
                end else begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StImm: begin
                state_d = StWait;
                timer_d = '0;
            end
            StWait: begin
                // Done wins over a timeout landing on the same cycle.
                if (bus.Done) begin
                    if (last_word) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StIssue;
                        pc_d    = pc_inc;
                        din_d   = mem_q[pc_inc];
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        run_d    = (state_d == StIssue);
        busy_d   = (state_d == StIssue) || (state_d == StImm) || (state_d == StWait);
        halted_d = (state_d == StHalt);
        error_d  = (state_d == StErr);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            len_q    <= '0;
            din_q    <= '0;
            timer_q  <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            din_q    <= din_d;
            timer_q  <= timer_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    assign bus.DIN    = din_q;
    assign bus.Run    = run_q;
    assign bus.PC     = pc_q;
    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios with literal expectations plus a long randomized
// run, all outputs compared every cycle against a behavioural model of the sequencing rules.
module tb_instr_sequencer;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned TIMEOUT = 15;
    localparam int MIdle = 0, MIssue = 1, MImm = 2, MWait = 3, MHalt = 4, MErr = 5;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_sequencer #(
        .ADDR_W (ADDR_W),
        .MVI_OP (3'b001),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode = MIdle;
    int m_pc   = 0;
    int m_len  = 0;
    int m_din  = 0;
    int m_wait = 0;
    bit [8:0] mm [DEPTH];

    task automatic model_step();
        bit open;
        open = (m_mode == MIdle) || (m_mode == MHalt) || (m_mode == MErr);
        case (m_mode)
            MIdle, MHalt, MErr: begin
                if (bus.Start) begin
                    if (bus.prog_len == 0) m_mode = MHalt;
                    else if (int'(bus.prog_len) > DEPTH) m_mode = MErr;
                    else begin
                        m_len  = int'(bus.prog_len);
                        m_pc   = 0;
                        m_din  = mm[0];
                        m_mode = MIssue;
                    end
                end
            end
            MIssue: begin
                if (m_din / 64 == 1) begin
                    if (m_pc + 1 == m_len) m_mode = MErr;
                    else begin
                        m_pc   = (m_pc + 1) % DEPTH;
                        m_din  = mm[m_pc];
                        m_mode = MImm;
                    end
                end else begin
                    m_mode = MWait;
                    m_wait = 0;
                end
            end
            MImm: begin
                m_mode = MWait;
                m_wait = 0;
            end
            MWait: begin
                if (bus.Done) begin
                    if (m_pc + 1 == m_len) m_mode = MHalt;
                    else begin
                        m_pc   = (m_pc + 1) % DEPTH;
                        m_din  = mm[m_pc];
                        m_mode = MIssue;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) m_mode = MErr;
                end
            end
            default: m_mode = MIdle;
        endcase
        if (open && bus.load_en) mm[bus.load_addr] = bus.load_data;
    endtask

    initial forever begin
        @(posedge Clock or negedge Resetn);
        if (!Resetn) begin
            m_mode = MIdle;
            m_pc   = 0;
            m_len  = 0;
            m_din  = 0;
            m_wait = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge Clock);
        if (cmp_en) begin
            chk("Run", int'(bus.Run), int'(m_mode == MIssue));
            chk("DIN", int'(bus.DIN), m_din);
            chk("PC", int'(bus.PC), m_pc);
            chk("busy", int'(bus.busy), int'(m_mode == MIssue || m_mode == MImm || m_mode == MWait));
            chk("halted", int'(bus.halted), int'(m_mode == MHalt));
            chk("error", int'(bus.error), int'(m_mode == MErr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int a, input int d);
        bus.load_en   = 1'b1;
        bus.load_addr = ADDR_W'(a);
        bus.load_data = 9'(d);
        step();
        bus.load_en = 1'b0;
    endtask

    task automatic start(input int n);
        bus.prog_len = (ADDR_W + 1)'(n);
        bus.Start    = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic done_pulse();
        bus.Done = 1'b1;
        step();
        bus.Done = 1'b0;
    endtask

    initial begin
        logic [8:0] d;
        int dp;
        bus.Start     = 1'b0;
        bus.prog_len  = '0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.Done      = 1'b0;
        cmp_en        = 1'b1;
        step();
        step();
        chk("rst_run", int'(bus.Run), 0);
        chk("rst_din", int'(bus.DIN), 0);
        chk("rst_pc", int'(bus.PC), 0);
        chk("rst_flags", int'({bus.busy, bus.halted, bus.error}), 0);
        Resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) load(i, 0);

        // Single plain instruction, Done three cycles after Run.
        start(1);
        chk("t1_run", int'(bus.Run), 1);
        chk("t1_din", int'(bus.DIN), 0);
        step();
        chk("t1_run_drop", int'(bus.Run), 0);
        step();
        step();
        done_pulse();
        chk("t1_halted", int'(bus.halted), 1);
        chk("t1_pc", int'(bus.PC), 0);

        // MVI with immediate, then a second instruction.
        load(0, 9'h040);
        load(1, 5);
        load(2, 9'h081);
        start(3);
        chk("t2_run0", int'(bus.Run), 1);
        chk("t2_din0", int'(bus.DIN), 9'h040);
        step();
        chk("t2_imm_run", int'(bus.Run), 0);
        chk("t2_imm_din", int'(bus.DIN), 5);
        chk("t2_imm_pc", int'(bus.PC), 1);
        step();
        done_pulse();
        chk("t2_run2", int'(bus.Run), 1);
        chk("t2_din2", int'(bus.DIN), 9'h081);
        step();
        done_pulse();
        chk("t2_halted", int'(bus.halted), 1);
        chk("t2_pc", int'(bus.PC), 2);

        // MVI as the last word: truncated immediate.
        load(0, 0);
        load(1, 9'h040);
        start(2);
        step();
        done_pulse();
        chk("t3_run1", int'(bus.Run), 1);
        chk("t3_pc1", int'(bus.PC), 1);
        step();
        chk("t3_error", int'(bus.error), 1);
        chk("t3_run_off", int'(bus.Run), 0);
        start(1);
        chk("t3_err_clr", int'(bus.error), 0);
        chk("t3_rerun", int'(bus.Run), 1);
        step();
        done_pulse();

        // Watchdog: no Done after Run.
        start(1);
        step();
        repeat (TIMEOUT - 1) step();
        chk("t4_no_err_yet", int'(bus.error), 0);
        step();
        chk("t4_error", int'(bus.error), 1);
        chk("t4_busy", int'(bus.busy), 0);

        // Dropped writes while busy, ignored Start and Done.
        start(1);
        step();
        start(0);
        chk("t5_start_ignored", int'(bus.busy), 1);
        load(0, 9'h1FF);
        done_pulse();
        chk("t5_halted", int'(bus.halted), 1);
        done_pulse();
        chk("t5_done_ignored", int'({bus.halted, bus.busy}), 2);
        start(1);
        chk("t5_readback", int'(bus.DIN), 0);
        step();
        done_pulse();

        // Asynchronous reset during IMM.
        load(0, 9'h040);
        load(1, 7);
        start(2);
        step();
        chk("t6_imm_din", int'(bus.DIN), 7);
        #1 Resetn = 1'b0;
        #1;
        chk("t6_rst_run", int'(bus.Run), 0);
        chk("t6_rst_din", int'(bus.DIN), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        step();
        Resetn = 1'b1;
        done_pulse();
        chk("t6_idle_done", int'({bus.busy, bus.halted, bus.error}), 0);
        start(0);
        chk("t6_halt_len0", int'(bus.halted), 1);
        chk("t6_no_run", int'(bus.Run), 0);
        start(33);
        chk("t6_too_long", int'(bus.error), 1);

        // Randomized run against the model.
        for (int c = 0; c < 4000; c++) begin
            dp = (c < 2000) ? 3 : 24;
            bus.Start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) bus.prog_len = (ADDR_W + 1)'($urandom_range(0, 33));
            else bus.prog_len = (ADDR_W + 1)'($urandom_range(1, 6));
            bus.load_en = ($urandom_range(0, 3) == 0);
            bus.load_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            d = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 2) == 0) d[8:6] = 3'b001;
            bus.load_data = d;
            bus.Done = ($urandom_range(0, dp - 1) == 0);
            Resetn = ($urandom_range(0, 599) != 0);
            step();
        end
        Resetn = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the 9-bit processor core. Holds a small loadable program store.
- Drives the core's DIN word and Run strobe, then waits for the core's Done pulse before issuing the next instruction.
- Replaces the free-running memory counter with a Done-paced handshake: one instruction in flight, immediate words supplied on the following cycle, watchdog on a missing Done.
- Runs entirely in the processor clock domain.

Parameters:
ADDR_W, 5, program-store address width; DEPTH = 2**ADDR_W words of 9 bits
MVI_OP, 3'b001, opcode in IR[8:6] that takes a second (immediate) word
TIMEOUT, 15, max cycles in WAIT without Done before error; must be >= 1

Ports:
Clock  input  1  processor clock; all state updates on rising edge
Resetn  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse: begin execution at address 0 (honoured in IDLE/HALT/ERR only)
prog_len  input  ADDR_W+1  number of words to execute, 0..DEPTH; sampled on accepted Start
load_en  input  1  write strobe for the program store
load_addr  input  ADDR_W  write address
load_data  input  9  write data
Done  input  1  from core: instruction complete (single-cycle pulse)
DIN  output  9  instruction/immediate word to core
Run  output  1  to core: instruction valid on DIN this cycle
PC  output  ADDR_W  address of current word
busy  output  1  high in ISSUE/IMM/WAIT
halted  output  1  high in HALT
error  output  1  high in ERR

Behaviour:
- Reset (async, Resetn=0): state=IDLE, PC=0, DIN=0, Run=0, busy=0, halted=0, error=0, timer=0, latched length=0. Program store contents are not reset.
- Store: DEPTH x 9 register array with combinational read. A write with load_en=1 takes effect at the clock edge, only in IDLE/HALT/ERR; in all other states writes are silently dropped.
- DIN is registered. It is loaded with mem[PC] on the edge entering ISSUE or IMM and held otherwise.
- IDLE:
  - Start with prog_len=0 -> HALT.
  - Start with prog_len>DEPTH -> ERR.
  - Start otherwise -> ISSUE; latch length, PC=0.
- ISSUE (1 cycle): Run=1, DIN=instruction.
  - If DIN[8:6]==MVI_OP: if PC+1==length -> ERR (truncated immediate); else PC<=PC+1 -> IMM.
  - Otherwise -> WAIT.
  - Timer is cleared on entry to WAIT.
- IMM (1 cycle): Run=0, DIN=immediate word -> WAIT.
- WAIT: Run=0, DIN held, timer increments each cycle.
  - On Done: if PC+1==length -> HALT (PC holds the last address); else PC<=PC+1 -> ISSUE.
  - If timer reaches TIMEOUT without Done -> ERR.
  - Done on the same cycle timer hits TIMEOUT counts as success.
- HALT / ERR: outputs held, Run=0. Start re-launches exactly as from IDLE, clearing halted/error on the launch edge.
- Done received outside WAIT is ignored and does not change state.
- Start received while busy is ignored.
- Issue latency: Start edge -> Run=1 on the next cycle. After Done, the next Run is asserted on the cycle after the Done sample.
- PC arithmetic is ADDR_W-bit. The compare against length uses ADDR_W+1 bits, so length=DEPTH terminates correctly at PC=DEPTH-1 without wrap.
- Reset asserted mid-operation returns to IDLE immediately, with Run forced low asynchronously.

Test Plan:
- Load mem[0]=9'o000 (mv), prog_len=1, Start; Done pulse 3 cycles after Run -> Run high 1 cycle with DIN=9'o000; halted=1 the cycle after Done; PC=0.
- Load mem[0]=9'b001_000_000, mem[1]=9'd5, mem[2]=9'b010_000_001, prog_len=3; Done after each instruction -> Run cycle DIN=0x040, next cycle DIN=5 with Run=0, then Run with DIN=0x081; HALT with PC=2.
- prog_len=2 with mem[1] an MVI -> first instruction completes; on issuing address 1, error=1 and Run deasserts; Start with prog_len=1 clears error and runs.
- Never pulse Done after the first Run -> error=1 exactly TIMEOUT cycles after entering WAIT; busy=0.
- load_en pulses during WAIT are dropped (store unchanged on readback run); Done pulse during IDLE is ignored; Start while busy is ignored.
- Assert Resetn=0 during IMM -> Run=0, DIN=0, state IDLE immediately; prog_len=0 Start -> halted=1 with no Run pulse.
